// File: rtl/bf16_pkg.sv
// bf16_pkg: shared FSM state type and constants for the bfloat16 FMA arbiter
package bf16_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FLAG_W = 5;
endpackage

// File: rtl/bf16_fma_arbiter_if.sv
// bf16_fma_arbiter_if: requester, response and FMA-core signals of the arbiter
// master = arbiter side (drives grants, responses, core issue); slave = requesters and core
interface bf16_fma_arbiter_if
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FLAG_W  = DEF_FLAG_W
);
    localparam int GW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*DATA_W-1:0] req_c;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [FLAG_W-1:0]         rsp_flags;
    logic                      rsp_timeout;
    logic                      fma_valid;
    logic                      fma_ready;
    logic [DATA_W-1:0]         fma_a;
    logic [DATA_W-1:0]         fma_b;
    logic [DATA_W-1:0]         fma_c;
    logic                      fma_done;
    logic [DATA_W-1:0]         fma_result;
    logic [FLAG_W-1:0]         fma_flags;
    logic                      busy;
    logic [GW-1:0]             grant_id;
    modport master (
        input  req_valid, req_a, req_b, req_c, rsp_ready, fma_ready, fma_done, fma_result, fma_flags,
        output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_timeout, fma_valid, fma_a, fma_b, fma_c,
               busy, grant_id
    );
    modport slave (
        output req_valid, req_a, req_b, req_c, rsp_ready, fma_ready, fma_done, fma_result, fma_flags,
        input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_timeout, fma_valid, fma_a, fma_b, fma_c,
               busy, grant_id
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; scans last_grant+1, +2, ... mod NUM_REQ
// Ports: req (request vector), last_grant (previous winner), gnt (one-hot), idx (winner index)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GW-1:0]      idx
);
    logic [GW-1:0] j;
    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = GW'((int'(last_grant) + i) % NUM_REQ);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/bf16_fma_arbiter.sv
// bf16_fma_arbiter: shares one bfloat16 FMA core between NUM_REQ requesters, one op in flight
// Ports: clk; reset_n (async, active-low); bus (master modport): per-requester request/accept,
//        one-hot response with shared data/flags/timeout bus, core issue/done handshake, busy, grant_id
module bf16_fma_arbiter
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FLAG_W  = DEF_FLAG_W,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                reset_n,
    bf16_fma_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    state_t             state, state_n;
    logic [GW-1:0]      last_grant, gidx;
    logic [NUM_REQ-1:0] gnt;
    logic [CW-1:0]      wd;
    logic               timeout_hit;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
        .req       (bus.req_valid),
        .last_grant(last_grant),
        .gnt       (gnt),
        .idx       (gidx)
    );
    assign timeout_hit   = wd == CW'(TIMEOUT - 1);
    // Gated by reset_n so no accept pulse leaks while reset is held with requests pending.
    assign bus.req_ready = (state == IDLE && reset_n) ? gnt : '0;
    assign bus.rsp_valid = (state == RESP) ? NUM_REQ'(1) << bus.grant_id : '0;
    assign bus.fma_valid = state == ISSUE;
    assign bus.busy      = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |bus.req_valid ? ISSUE : IDLE;
            ISSUE:   state_n = bus.fma_ready ? WAIT : ISSUE;
            WAIT:    state_n = (bus.fma_done || timeout_hit) ? RESP : WAIT;
            RESP:    state_n = bus.rsp_ready[bus.grant_id] ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            last_grant      <= GW'(NUM_REQ - 1);
            wd              <= '0;
            bus.grant_id    <= '0;
            bus.fma_a       <= '0;
            bus.fma_b       <= '0;
            bus.fma_c       <= '0;
            bus.rsp_data    <= '0;
            bus.rsp_flags   <= '0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && |bus.req_valid) begin
                bus.grant_id <= gidx;
                bus.fma_a    <= bus.req_a[gidx*DATA_W +: DATA_W];
                bus.fma_b    <= bus.req_b[gidx*DATA_W +: DATA_W];
                bus.fma_c    <= bus.req_c[gidx*DATA_W +: DATA_W];
            end
            // Held at zero throughout ISSUE so WAIT always starts from a fresh count.
            if (state == ISSUE) wd <= '0;
            if (state == WAIT) begin
                wd <= wd + 1'b1;
                if (bus.fma_done) begin
                    bus.rsp_data    <= bus.fma_result;
                    bus.rsp_flags   <= bus.fma_flags;
                    bus.rsp_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    bus.rsp_data    <= DATA_W'(BF16_QNAN);
                    bus.rsp_flags   <= '0;
                    bus.rsp_timeout <= 1'b1;
                end
            end
            if (state == RESP && bus.rsp_ready[bus.grant_id]) last_grant <= bus.grant_id;
        end
    end
endmodule

// File: doc/bf16_fma_arbiter.md
Name: bf16_fma_arbiter

Overview:
- Shares one bfloat16 FMA core (`bfloat16_fma_wb` datapath, operand/start/done interface) between NUM_REQ requesters, e.g. Wishbone master, LA port and a future DMA sequencer.
- Round-robin grant with one operation in flight at a time.
- Drives the core's issue handshake and watches for completion with a watchdog.
- Returns result and exception flags to the requester that issued the operation.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 16, bfloat16 operand/result width
FLAG_W, 5, exception flag width from the FMA core
TIMEOUT, 64, cycles in WAIT before the watchdog fires (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  one-hot accept pulse
req_a  in  NUM_REQ*DATA_W  multiplicand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  multiplicand B
req_c  in  NUM_REQ*DATA_W  addend C
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_data  out  DATA_W  result, shared bus
rsp_flags  out  FLAG_W  exception flags, shared bus
rsp_timeout  out  1  response produced by the watchdog
fma_valid  out  1  issue request to FMA core
fma_ready  in  1  core accepts operands
fma_a, fma_b, fma_c  out  DATA_W each  latched operands
fma_done  in  1  single-cycle completion pulse
fma_result  in  DATA_W  core result, valid with fma_done
fma_flags  in  FLAG_W  core flags, valid with fma_done
busy  out  1  state != IDLE
grant_id  out  clog2(NUM_REQ)  index of current/last grant

Behaviour:
- Single clock clk. Reset is asynchronous and active-low on reset_n.
- Reset state:
  - State IDLE; req_ready, rsp_valid, fma_valid, busy, rsp_timeout all 0.
  - rsp_data, rsp_flags, fma_a/b/c all 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first; grant_id = 0; watchdog counter 0.
- IDLE:
  - If any req_valid, grant the first set bit scanning last_grant+1, +2, ... mod NUM_REQ.
  - Assert req_ready[g] combinationally in that same cycle, so the transfer completes on that edge.
  - Latch a/b/c into fma_a/b/c, set grant_id=g, go to ISSUE.
- ISSUE: fma_valid=1 and operands held stable. When fma_ready, go to WAIT and clear the watchdog; fma_valid drops next cycle.
- WAIT:
  - Watchdog increments each cycle.
  - On fma_done: latch fma_result/fma_flags, rsp_timeout=0, go to RESP.
  - If counter == TIMEOUT-1 and no fma_done: rsp_data=16'h7FC0 (qNaN), rsp_flags=0, rsp_timeout=1, go to RESP.
  - fma_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[grant_id]=1, held with data stable until rsp_ready[grant_id].
  - On acceptance: last_grant=grant_id, go to IDLE.
  - rsp_ready on other indices is ignored.
- No new grant in the cycle a response is accepted. Minimum turnaround is accept, ISSUE, WAIT, done, RESP = 4 cycles plus core latency.
- req_valid changes after acceptance have no effect on the in-flight op.
- req_ready is never asserted outside IDLE.
- fma_done outside WAIT is ignored.
- Reset asserted mid-operation: immediate return to reset state with no response emitted. The core is reset by its own path.
- At most one bit of req_ready and at most one bit of rsp_valid is ever set.

Decomposition:
- Shared package `bf16_pkg`:
  - state enum IDLE/ISSUE/WAIT/RESP
  - BF16_QNAN = 16'h7FC0
  - DATA_W/FLAG_W defaults
- One sub-module `rr_arbiter`: NUM_REQ-wide round-robin picker. Inputs: request vector and last_grant. Outputs: one-hot grant and index; purely combinational.
- Watchdog and FSM stay in the top.

Test Plan:
- Reset, then req_valid=01, a=3F80, b=4000, c=3F80; core returns 4040 after 3 cycles -> req_ready=01 in cycle 0, fma_valid in cycle 1, rsp_valid=01 with rsp_data=4040, rsp_timeout=0, busy back to 0 after rsp_ready.
- Both requesters held valid for 4 ops -> grant order 0,1,0,1; every rsp_valid bit matches the issuing index.
- fma_ready held low for 5 cycles in ISSUE -> fma_valid and operands stable for all 5 cycles; watchdog does not count.
- Core never pulses fma_done with TIMEOUT=8 -> rsp_valid 8 cycles after entering WAIT, rsp_data=7FC0, rsp_timeout=1.
- rsp_ready held low for 10 cycles, then stray fma_done and new req_valid -> response data unchanged, no req_ready until after acceptance.
- reset_n pulsed low while in WAIT -> all outputs 0 asynchronously; next request is granted to requester 0.
